demux_dist_9_1: RTL and testbench
=================================

Name: demux_dist_9_1

Overview:
- Registered 1-to-N stream distributor. It is the inverse of the balanced N:1 select mux.
- Takes one input stream, tagged with a lane select, and steers each accepted word into one of N per-lane holding registers.
- Each lane has its own valid/ready handshake.
- Sits between a shared producer and N independent consumers that each apply back-pressure.

Parameters:
N, 9, number of output lanes
W, 1, data width per lane in bits
SW, $clog2(N), select width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_data  input  W  input word
in_sel  input  SW  destination lane index
in_valid  input  1  input word present
in_ready  output  1  block accepts input this cycle
out_data  output  N*W  lane k data on out_data[k*W+:W]
out_valid  output  N  lane k holds a valid word
out_ready  input  N  lane k consumer accepts
drop_pulse  output  1  registered one-cycle flag: an out-of-range word was dropped

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-high: rst asserted clears state immediately, independent of clk.
  - While rst is high, out_valid=0, out_data=0 and drop_pulse=0.
  - Reset mid-transfer discards all held words; nothing is replayed after release.
- Lane states:
  - Each lane has two states, EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
- in_ready (combinational from in_sel, out_valid and out_ready):
  - in_sel < N: in_ready = !out_valid[in_sel] | out_ready[in_sel].
  - in_sel >= N: in_ready = 1. The word is sunk.
- Accept:
  - accept = in_valid & in_ready.
  - Data is taken only on accept.
  - in_data and in_sel may change freely when in_valid=0.
- Load, lane k = in_sel < N, on accept:
  - Next edge: out_data[k] <= in_data and out_valid[k] <= 1.
  - Latency is 1 cycle from accept to out_valid.
- Drain:
  - out_valid[k] & out_ready[k] with no load to lane k that cycle: FULL -> EMPTY next edge.
  - out_data[k] holds its last value; it is not cleared.
- Simultaneous drain and load on the same lane:
  - The lane stays FULL and takes the new data.
  - Full throughput: one word per cycle per lane.
- Other lanes:
  - Unselected lanes are unaffected by input activity.
  - Lanes drain independently; several lanes may drain in the same cycle.
- Out-of-range select (in_sel >= N):
  - On accept, no lane changes.
  - drop_pulse = 1 for exactly the following cycle.
  - Back-to-back drops hold drop_pulse high continuously.
- Boundary selects:
  - in_sel = N-1 is valid.
  - in_sel = N is the first dropped code.
  - When N is a power of two, no drop is possible.
- Blocked input:
  - If lane k is FULL with out_ready[k]=0, then in_ready=0 for in_sel=k, regardless of other lanes.
  - No head-of-line bypass: the producer must keep in_data and in_sel stable while in_valid=1 and in_ready=0.
- Output timing:
  - out_valid, out_data and drop_pulse are registered.
  - in_ready is the only combinational output.

Optional Feature:
- Macro: DEMUX_DIST_DROP_CNT_EN.
- Defined: adds output drop_count, 8 bits.
  - Reset to 0.
  - Increments on each out-of-range accept.
  - Saturates at 255; no wrap.
  - Updates in the same edge that sets drop_pulse.
- Undefined: the drop_count port and its counter do not exist. All other behaviour is identical.

Test Plan:
- Reset, N=9, W=8: assert rst mid-cycle with lanes FULL -> out_valid=9'h000, out_data=0 and drop_pulse=0 immediately, before the next clk edge.
- Load: in_sel=3, in_data=8'hA5, in_valid=1, all out_ready=0 -> in_ready=1. Next cycle out_valid=9'h008 and lane 3 data=8'hA5.
- Back-pressure then overlap:
  - With lane 3 FULL and out_ready[3]=0, send in_sel=3, in_data=8'h5A -> in_ready=0; lane 3 keeps 8'hA5.
  - Raise out_ready[3] -> accept; next cycle lane 3 = 8'h5A and out_valid[3] stays 1.
- Streaming: in_sel=8, data 1,2,3,4 on consecutive cycles with out_ready[8]=1 -> in_ready=1 every cycle; lane 8 shows 1,2,3,4 one cycle later with out_valid[8]=1 throughout.
- Out-of-range drop: in_sel=9, then 15, on consecutive cycles -> in_ready=1; drop_pulse high for 2 cycles; out_valid unchanged. With DEMUX_DIST_DROP_CNT_EN, drop_count=2.
- Saturation (DEMUX_DIST_DROP_CNT_EN): 300 drops -> drop_count=255.
- Independence: lanes 0 and 5 FULL; drain lane 0 only -> out_valid goes 9'h021 -> 9'h020, and lane 5 data is unchanged.

Source files
------------

// File: rtl/demux_dist_9_1.sv
// Registered 1-to-N stream distributor: each accepted word is steered by in_sel into a per-lane holding register.
// Optional DEMUX_DIST_DROP_CNT_EN adds a saturating 8-bit drop_count for out-of-range selects.
module demux_dist_9_1 #(
  parameter int N = 9,
  parameter int W = 1,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    in_data,
  input  logic [SW-1:0]   in_sel,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [N*W-1:0]  out_data,
  output logic [N-1:0]    out_valid,
  input  logic [N-1:0]    out_ready,
  output logic            drop_pulse
`ifdef DEMUX_DIST_DROP_CNT_EN
  ,
  output logic [7:0]      drop_count
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} lane_st_t;

  localparam logic [SW:0] SEL_LIM = (SW + 1)'(N);

  lane_st_t       r_st     [N];
  lane_st_t       w_st_nxt [N];
  logic [N*W-1:0] r_data;
  logic [N-1:0]   w_load;
  logic           r_drop;
  logic           w_in_range;
  logic           w_accept;
`ifdef DEMUX_DIST_DROP_CNT_EN
  logic [7:0]     r_drop_cnt;
`endif

  always_comb begin
    w_in_range = ({1'b0, in_sel} < SEL_LIM);
    in_ready   = 1'b1;
    if (w_in_range) in_ready = (r_st[in_sel] == EMPTY) | out_ready[in_sel];
    w_accept   = in_valid & in_ready;
  end

  // A load wins over a drain on the same lane, so a draining lane refills without a bubble.
  always_comb begin
    w_load = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_load[k]   = w_accept & w_in_range & (in_sel == SW'(k));
      w_st_nxt[k] = r_st[k];
      if (w_load[k])                              w_st_nxt[k] = FULL;
      else if ((r_st[k] == FULL) && out_ready[k]) w_st_nxt[k] = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < N; k++) r_st[k] <= EMPTY;
      r_data <= '0;
      r_drop <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        r_st[k] <= w_st_nxt[k];
        if (w_load[k]) r_data[k*W +: W] <= in_data;
      end
      r_drop <= w_accept & ~w_in_range;
    end
  end

`ifdef DEMUX_DIST_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                             r_drop_cnt <= '0;
    else if (w_accept && !w_in_range && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign drop_count = r_drop_cnt;
`endif

  always_comb begin
    out_valid = '0;
    for (int unsigned k = 0; k < N; k++) out_valid[k] = (r_st[k] == FULL);
  end

  assign out_data   = r_data;
  assign drop_pulse = r_drop;

endmodule

// File: tb/tb_demux_dist_9_1.sv
// Directed scoreboard bench for demux_dist_9_1 with N=9, W=8.
module tb_demux_dist_9_1;
  localparam int N = 9;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   in_data;
  logic [3:0]     in_sel;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready;
  logic           drop_pulse;
`ifdef DEMUX_DIST_DROP_CNT_EN
  logic [7:0]     drop_count;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0]   sel;
    logic [W-1:0] data;
    logic [N-1:0] vld;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  demux_dist_9_1 #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop_pulse(drop_pulse)
`ifdef DEMUX_DIST_DROP_CNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_check();
    exp_t e;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk("sb_out_valid", out_valid, e.vld);
    if (e.sel < N) chk("sb_lane_data", out_data[e.sel*W +: W], e.data);
    else           chk("sb_drop_pulse", drop_pulse, 1'b1);
  endtask

  // Offer one word; if a ready is expected, the outcome is queued and checked after the edge.
  task automatic xfer(input logic [3:0] sel, input logic [W-1:0] d, input logic rdy,
                      input logic [N-1:0] vld_after);
    in_sel   = sel;
    in_data  = d;
    in_valid = 1'b1;
    #1;
    chk("in_ready", in_ready, rdy);
    if (rdy) exp_q.push_back('{sel: sel, data: d, vld: vld_after});
    step();
    sb_check();
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 9'h000);
    chk("rst_out_data", out_data, '0);
    chk("rst_drop_pulse", drop_pulse, 1'b0);
`ifdef DEMUX_DIST_DROP_CNT_EN
    chk("rst_drop_count", drop_count, 8'd0);
`endif
    rst = 1'b0;
    step();

    xfer(4'd3, 8'hA5, 1'b1, 9'h008);
    in_valid = 1'b0;
    chk("load_out_valid", out_valid, 9'h008);

    xfer(4'd3, 8'h5A, 1'b0, 9'h008);
    chk("blocked_lane3_data", out_data[3*W +: W], 8'hA5);
    chk("blocked_out_valid", out_valid, 9'h008);
    out_ready[3] = 1'b1;
    #1;
    chk("overlap_in_ready", in_ready, 1'b1);
    exp_q.push_back('{sel: 4'd3, data: 8'h5A, vld: 9'h008});
    step();
    sb_check();
    in_valid  = 1'b0;
    out_ready = '0;

    out_ready = 9'h100;
    for (int i = 1; i <= 4; i++) xfer(4'd8, W'(i), 1'b1, 9'h108);
    in_valid = 1'b0;
    step();
    chk("stream_drained", out_valid, 9'h008);
    chk("stream_last_hold", out_data[8*W +: W], 8'h04);

    out_ready = '0;
    xfer(4'd9,  8'hEE, 1'b1, 9'h008);
    xfer(4'd15, 8'hEF, 1'b1, 9'h008);
    in_valid = 1'b0;
    step();
    chk("drop_pulse_end", drop_pulse, 1'b0);
    chk("drop_lane3_kept", out_data[3*W +: W], 8'h5A);
`ifdef DEMUX_DIST_DROP_CNT_EN
    chk("drop_count_2", drop_count, 8'd2);
`endif

    out_ready = 9'h008;
    step();
    out_ready = '0;
    chk("drain3_out_valid", out_valid, 9'h000);
    chk("drain3_data_hold", out_data[3*W +: W], 8'h5A);
    xfer(4'd0, 8'h11, 1'b1, 9'h001);
    xfer(4'd5, 8'h55, 1'b1, 9'h021);
    in_valid  = 1'b0;
    out_ready = 9'h001;
    step();
    out_ready = '0;
    chk("indep_out_valid", out_valid, 9'h020);
    chk("indep_lane5_data", out_data[5*W +: W], 8'h55);
    chk("indep_lane0_hold", out_data[0*W +: W], 8'h11);

    in_sel = 4'd5;
    #1;
    chk("hol_sel5_ready", in_ready, 1'b0);
    in_sel = 4'd0;
    #1;
    chk("hol_sel0_ready", in_ready, 1'b1);
    in_sel = 4'd9;
    #1;
    chk("sel9_ready", in_ready, 1'b1);
    step();

    xfer(4'd12, 8'h00, 1'b1, 9'h020);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 9'h000);
    chk("arst_out_data", out_data, '0);
    chk("arst_drop_pulse", drop_pulse, 1'b0);
`ifdef DEMUX_DIST_DROP_CNT_EN
    chk("arst_drop_count", drop_count, 8'd0);
`endif
    step();
    rst = 1'b0;
    step();
    chk("post_rst_no_replay", out_valid, 9'h000);

`ifdef DEMUX_DIST_DROP_CNT_EN
    in_sel   = 4'd9;
    in_valid = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("sat_drop_count", drop_count, 8'd255);
    step();
    chk("sat_hold", drop_count, 8'd255);
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
